// File: rtl/xgmii_numa_tx.sv
// xgmii_numa_tx: turns remote-memory write requests into minimum-size
// Ethernet/IPv4/UDP frames on a 64-bit XGMII transmit lane.
// The whole 60-byte frame body is built when a request is accepted.
// The CRC is then accumulated one word per DATA cycle, so the FCS is
// ready when word 7 goes out.
//
//   state | meaning
//   IDLE  | idle word out, req_ready high, waiting for a request
//   PRE   | start + preamble + SFD word out
//   DATA  | frame words 0..7 out (wcnt = word on the lane)
//   TERM  | /T/ word out
//   IFG   | one idle word, then back to IDLE
module xgmii_numa_tx #(
  parameter logic [15:0] UDP_SRC_PORT = 16'h3776,
  parameter logic [15:0] UDP_DST_PORT = 16'h3776,
  parameter logic [15:0] OPCODE       = 16'h0001
) (
  input  logic        xgmii_clk,
  input  logic        rst,
  input  logic [31:0] if_v4addr,
  input  logic [47:0] if_macaddr,
  input  logic [31:0] dest_v4addr,
  input  logic [47:0] dest_macaddr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_be,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [31:0] frame_count
);

  localparam logic [63:0] IDLE_WORD = 64'h07070707_07070707;
  localparam logic [63:0] PRE_WORD  = 64'hd5555555_555555fb;
  localparam logic [63:0] TERM_WORD = 64'h07070707_070707fd;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_TERM, S_IFG} state_t;

  state_t      state;
  logic [2:0]  wcnt;
  logic [511:0] frame_q;  // byte b at bits [8*b +: 8]; top 32 bits always zero
  logic [31:0] crc_q;
  logic [15:0] ip_id;

  logic [2:0]  nxt_idx;
  logic [63:0] word_raw;
  logic [63:0] data_word;
  logic [31:0] crc_nxt;
  logic [31:0] fcs;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [63:0] d,
                                           input int nbytes);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      if (i < nbytes) r = crc_byte(r, d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [15:0] ip_csum(input logic [15:0] id, input logic [31:0] sip,
                                          input logic [31:0] dip);
    logic [19:0] s;
    s = 20'h04500 + 20'h0002e + {4'h0, id} + 20'h04000 + 20'h04011
      + {4'h0, sip[31:16]} + {4'h0, sip[15:0]} + {4'h0, dip[31:16]} + {4'h0, dip[15:0]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0, s[19:16]};
    return ~s[15:0];
  endfunction

  // Header fields are laid out first-byte-at-MSB, then byte-reversed so
  // that frame byte b lands in lane b%8 of word b/8.
  function automatic logic [511:0] build_frame(
    input logic [47:0] dmac, input logic [47:0] smac,
    input logic [31:0] sip,  input logic [31:0] dip, input logic [15:0] id,
    input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    logic [479:0] msb;
    logic [511:0] f;
    msb = {dmac, smac, 16'h0800,
           16'h4500, 16'h002e, id, 16'h4000, 8'h40, 8'h11, ip_csum(id, sip, dip), sip, dip,
           UDP_SRC_PORT, UDP_DST_PORT, 16'h001a, 16'h0000,
           OPCODE, addr, data, 4'h0, be, 56'h0};
    f = '0;
    for (int i = 0; i < 60; i++)
      f[8*i +: 8] = msb[479-8*i -: 8];
    return f;
  endfunction

  // Next DATA word to present, with the FCS spliced into the upper half of word 7
  always_comb begin
    nxt_idx   = (state == S_PRE) ? 3'd0 : wcnt + 3'd1;
    word_raw  = frame_q[{nxt_idx, 6'b0} +: 64];
    fcs       = ~crc_word(crc_q, {32'h0, frame_q[479:448]}, 4);
    data_word = (nxt_idx == 3'd7) ? {fcs, frame_q[479:448]} : word_raw;
    crc_nxt   = crc_word((state == S_PRE) ? 32'hFFFFFFFF : crc_q, word_raw, 8);
  end

  // Frame sequencer with registered XGMII outputs, ready and counters
  always_ff @(posedge xgmii_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wcnt        <= 3'd0;
      ip_id       <= 16'h0;
      frame_count <= 32'h0;
      xgmii_txd   <= IDLE_WORD;
      xgmii_txc   <= 8'hff;
      req_ready   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            frame_q   <= build_frame(dest_macaddr, if_macaddr, if_v4addr, dest_v4addr,
                                     ip_id, req_addr, req_data, req_be);
            state     <= S_PRE;
            xgmii_txd <= PRE_WORD;
            xgmii_txc <= 8'h01;
            req_ready <= 1'b0;
          end else begin
            xgmii_txd <= IDLE_WORD;
            xgmii_txc <= 8'hff;
            req_ready <= 1'b1;
          end
        end
        S_PRE: begin
          state     <= S_DATA;
          wcnt      <= 3'd0;
          xgmii_txd <= data_word;
          xgmii_txc <= 8'h00;
          crc_q     <= crc_nxt;
        end
        S_DATA: begin
          if (wcnt == 3'd7) begin
            state     <= S_TERM;
            xgmii_txd <= TERM_WORD;
            xgmii_txc <= 8'hff;
          end else begin
            wcnt      <= wcnt + 3'd1;
            xgmii_txd <= data_word;
            crc_q     <= crc_nxt;
          end
        end
        S_TERM: begin
          state       <= S_IFG;
          xgmii_txd   <= IDLE_WORD;
          xgmii_txc   <= 8'hff;
          ip_id       <= ip_id + 16'h1;
          frame_count <= frame_count + 32'h1;
        end
        S_IFG: begin
          state     <= S_IDLE;
          xgmii_txd <= IDLE_WORD;
          xgmii_txc <= 8'hff;
          req_ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_numa_tx.sv
// Bench for xgmii_numa_tx: byte-level frame model feeding a scoreboard
// queue, a small table of requests with hand-computed header values, and
// directed sequences for back-to-back, address change, ip_id wrap and
// mid-frame reset.
module tb_xgmii_numa_tx;

  localparam logic [63:0] IDLE_W = 64'h07070707_07070707;
  localparam logic [63:0] PRE_W  = 64'hd5555555_555555fb;
  localparam logic [63:0] TERM_W = 64'h07070707_070707fd;
  localparam logic [31:0] DEF_SIP  = 32'h0a0015c7;
  localparam logic [47:0] DEF_SMAC = 48'h003776000001;
  localparam logic [31:0] DEF_DIP  = 32'h0a0015ff;
  localparam logic [47:0] DEF_DMAC = 48'hffffffffffff;

  logic        xgmii_clk = 1'b0;
  logic        rst;
  logic [31:0] if_v4addr, dest_v4addr, req_addr, req_data;
  logic [47:0] if_macaddr, dest_macaddr;
  logic        req_valid, req_ready;
  logic [3:0]  req_be;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [31:0] frame_count;

  always #5 xgmii_clk = ~xgmii_clk;

  xgmii_numa_tx dut (
    .xgmii_clk(xgmii_clk), .rst(rst),
    .if_v4addr(if_v4addr), .if_macaddr(if_macaddr),
    .dest_v4addr(dest_v4addr), .dest_macaddr(dest_macaddr),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .frame_count(frame_count)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] txd;
    logic [7:0]  txc;
    logic [31:0] fc;
    int          idx;
  } ent_t;

  ent_t        sbq[$];
  int          acc_time[$];
  logic        rst_q = 1'b1;
  int          cyc = 0;
  int          acc_cnt = 0;
  logic [15:0] ipid_m = 16'h0;
  logic [31:0] fc_m = 32'h0;
  logic [63:0] cap [8];
  logic [7:0]  fb [64];
  logic [63:0] ew [8];

  // Reference frame built byte by byte, then packed into lane order
  task automatic build_model(input logic [47:0] dmac, input logic [47:0] smac,
                             input logic [31:0] sip, input logic [31:0] dip,
                             input logic [15:0] id, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
    int unsigned sum;
    logic [31:0] c;
    logic [15:0] ck;
    for (int i = 0; i < 64; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dmac[47-8*i -: 8];
      fb[6 + i] = smac[47-8*i -: 8];
    end
    fb[12] = 8'h08; fb[13] = 8'h00;
    fb[14] = 8'h45; fb[15] = 8'h00; fb[16] = 8'h00; fb[17] = 8'h2e;
    fb[18] = id[15:8]; fb[19] = id[7:0];
    fb[20] = 8'h40; fb[21] = 8'h00; fb[22] = 8'h40; fb[23] = 8'h11;
    for (int i = 0; i < 4; i++) begin
      fb[26 + i] = sip[31-8*i -: 8];
      fb[30 + i] = dip[31-8*i -: 8];
      fb[44 + i] = addr[31-8*i -: 8];
      fb[48 + i] = data[31-8*i -: 8];
    end
    fb[34] = 8'h37; fb[35] = 8'h76; fb[36] = 8'h37; fb[37] = 8'h76;
    fb[38] = 8'h00; fb[39] = 8'h1a;
    fb[42] = 8'h00; fb[43] = 8'h01;
    fb[52] = {4'h0, be};
    sum = 0;
    for (int j = 0; j < 10; j++) sum += {16'h0, fb[14+2*j], fb[15+2*j]};
    while ((sum >> 16) != 0) sum = (sum & 32'hffff) + (sum >> 16);
    ck = ~sum[15:0];
    fb[24] = ck[15:8]; fb[25] = ck[7:0];
    c = 32'hFFFFFFFF;
    for (int b = 0; b < 60; b++) begin
      c = c ^ {24'h0, fb[b]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    fb[60] = c[7:0]; fb[61] = c[15:8]; fb[62] = c[23:16]; fb[63] = c[31:24];
    for (int w = 0; w < 8; w++)
      for (int l = 0; l < 8; l++) ew[w][8*l +: 8] = fb[8*w + l];
  endtask

  always @(posedge xgmii_clk) begin
    rst_q <= rst;
    cyc   <= cyc + 1;
  end

  // Scoreboard: compare every output cycle, and predict accepts
  always @(negedge xgmii_clk) begin
    logic popped;
    ent_t e;
    popped = 1'b0;
    if (rst_q) begin
      sbq.delete();
      ipid_m = 16'h0;
      fc_m   = 32'h0;
      chk("rst_txd", xgmii_txd, IDLE_W);
      chk("rst_txc", 64'(xgmii_txc), 64'hff);
      chk("rst_ready", 64'(req_ready), 64'h0);
      chk("rst_fc", 64'(frame_count), 64'h0);
    end else if (sbq.size() > 0) begin
      e = sbq.pop_front();
      popped = 1'b1;
      chk("frm_txd", xgmii_txd, e.txd);
      chk("frm_txc", 64'(xgmii_txc), 64'(e.txc));
      chk("frm_fc", 64'(frame_count), 64'(e.fc));
      chk("frm_ready", 64'(req_ready), 64'h0);
      if (e.idx >= 0) cap[e.idx] = xgmii_txd;
    end else begin
      chk("idle_txd", xgmii_txd, IDLE_W);
      chk("idle_txc", 64'(xgmii_txc), 64'hff);
      chk("idle_ready", 64'(req_ready), 64'h1);
      chk("idle_fc", 64'(frame_count), 64'(fc_m));
    end
    if (!rst_q && !popped && !rst && req_valid) begin
      build_model(dest_macaddr, if_macaddr, if_v4addr, dest_v4addr, ipid_m,
                  req_addr, req_data, req_be);
      sbq.push_back('{PRE_W, 8'h01, fc_m, -1});
      for (int i = 0; i < 8; i++) sbq.push_back('{ew[i], 8'h00, fc_m, i});
      sbq.push_back('{TERM_W, 8'hff, fc_m, -1});
      sbq.push_back('{IDLE_W, 8'hff, fc_m + 32'h1, -1});
      acc_cnt++;
      acc_time.push_back(cyc);
      ipid_m = ipid_m + 16'h1;
      fc_m   = fc_m + 32'h1;
    end
  end

  task automatic send_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    int n0;
    bit ok;
    n0 = acc_cnt;
    ok = 1'b0;
    req_addr = addr; req_data = data; req_be = be;
    req_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge xgmii_clk); #1;
      if (acc_cnt != n0) begin ok = 1'b1; break; end
    end
    req_valid = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL accept_timeout: got none expected 1"); end
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge xgmii_clk); #1;
      if (sbq.size() == 0) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL frame_timeout: got %0d left expected 0", sbq.size()); end
  endtask

  function automatic logic [15:0] cap_id();
    return {cap[2][23:16], cap[2][31:24]};
  endfunction
  function automatic logic [15:0] cap_cks();
    return {cap[3][7:0], cap[3][15:8]};
  endfunction
  function automatic logic [31:0] cap_dip();
    return {cap[3][55:48], cap[3][63:56], cap[4][7:0], cap[4][15:8]};
  endfunction

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [15:0] exp_id;
    logic [15:0] exp_cks;
  } vec_t;

  vec_t vt [3];

  initial begin
    int t0, n0;
    vt[0] = '{32'h00001000, 32'hdeadbeef, 4'hf, 16'h0000, 16'hfaf9};
    vt[1] = '{32'h12345678, 32'h00000000, 4'h3, 16'h0001, 16'hfaf8};
    vt[2] = '{32'hffffffff, 32'ha5a5a5a5, 4'h0, 16'h0002, 16'hfaf7};

    rst = 1'b1; req_valid = 1'b0;
    req_addr = '0; req_data = '0; req_be = '0;
    if_v4addr = DEF_SIP; if_macaddr = DEF_SMAC;
    dest_v4addr = DEF_DIP; dest_macaddr = DEF_DMAC;
    repeat (3) @(posedge xgmii_clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge xgmii_clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      send_req(vt[i].addr, vt[i].data, vt[i].be);
      wait_done();
      chk("tbl_id", 64'(cap_id()), 64'(vt[i].exp_id));
      chk("tbl_cks", 64'(cap_cks()), 64'(vt[i].exp_cks));
      chk("tbl_addr", 64'({cap[5][39:32], cap[5][47:40], cap[5][55:48], cap[5][63:56]}),
          64'(vt[i].addr));
      chk("tbl_data", 64'({cap[6][7:0], cap[6][15:8], cap[6][23:16], cap[6][31:24]}),
          64'(vt[i].data));
      chk("tbl_be", 64'(cap[6][39:32]), 64'({4'h0, vt[i].be}));
      if (i == 0) begin
        chk("first_word0", cap[0], 64'h3700ffff_ffffffff);
        chk("first_word5", cap[5], 64'h00100000_01000000);
        chk("first_word6", cap[6], 64'h0000000f_efbeadde);
        chk("first_fc", 64'(frame_count), 64'h1);
      end
    end

    // back-to-back: req_valid held across three accepts
    t0 = acc_time.size();
    n0 = acc_cnt;
    req_addr = 32'h00002000; req_data = 32'h01020304; req_be = 4'h5;
    req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge xgmii_clk); #1;
      if (acc_cnt >= n0 + 3) break;
    end
    req_valid = 1'b0;
    chk("b2b_count", 64'(acc_cnt - n0), 64'h3);
    wait_done();
    if (acc_time.size() >= t0 + 3) begin
      chk("b2b_gap1", 64'(acc_time[t0+1] - acc_time[t0]), 64'd12);
      chk("b2b_gap2", 64'(acc_time[t0+2] - acc_time[t0+1]), 64'd12);
    end
    chk("b2b_id", 64'(cap_id()), 64'h5);
    chk("b2b_cks", 64'(cap_cks()), 64'hfaf4);

    // destination change right after accept only affects the next frame
    send_req(32'h00003000, 32'hcafef00d, 4'hc);
    dest_v4addr = 32'h0a001501;
    wait_done();
    chk("dst_old", 64'(cap_dip()), 64'h0a0015ff);
    send_req(32'h00003004, 32'h0badf00d, 4'h1);
    wait_done();
    chk("dst_new", 64'(cap_dip()), 64'h0a001501);
    chk("dst_new_cks", 64'(cap_cks()), 64'hfbf0);
    dest_v4addr = DEF_DIP;

    // ip_id wrap
    @(posedge xgmii_clk); #1;
    force dut.ip_id = 16'hffff;
    @(posedge xgmii_clk); #1;
    release dut.ip_id;
    ipid_m = 16'hffff;
    send_req(32'h00004000, 32'h11111111, 4'hf);
    wait_done();
    chk("wrap_ffff", 64'(cap_id()), 64'hffff);
    send_req(32'h00004004, 32'h22222222, 4'hf);
    wait_done();
    chk("wrap_0000", 64'(cap_id()), 64'h0000);
    chk("wrap_cks", 64'(cap_cks()), 64'hfaf9);

    // reset while DATA word 3 is on the lane
    send_req(32'h00005000, 32'h33333333, 4'hf);
    repeat (4) @(posedge xgmii_clk);
    #1 rst = 1'b1;
    @(posedge xgmii_clk);
    #1 rst = 1'b0;
    chk("rst_mid_txc", 64'(xgmii_txc), 64'hff);
    chk("rst_mid_fc", 64'(frame_count), 64'h0);
    repeat (2) @(posedge xgmii_clk);
    #1;
    send_req(32'h00006000, 32'h44444444, 4'ha);
    wait_done();
    chk("post_rst_id", 64'(cap_id()), 64'h0);
    chk("post_rst_fc", 64'(frame_count), 64'h1);

    repeat (3) @(posedge xgmii_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xgmii_numa_tx.md
# xgmii_numa_tx

Ethernet/IPv4/UDP frame generator that turns remote-memory write requests into minimum-size 64-byte frames on a 10G XGMII transmit lane. It sits between the PCIe user-register block and the XGMII PHY interface, where the idle-only transmit stub sits today. Addressing comes from the PCIe user registers: local IPv4/MAC and destination IPv4/MAC. Each accepted request produces exactly one frame with a valid IPv4 header checksum and Ethernet FCS.

## Interface
- UDP_SRC_PORT, 16'h3776, UDP source port
- UDP_DST_PORT, 16'h3776, UDP destination port
- OPCODE, 16'h0001, first two payload bytes

- xgmii_clk  in  1  156.25 MHz XGMII clock; the only clock
- rst  in  1  synchronous, active-high reset
- if_v4addr  in  32  local IPv4 address, MSB = first octet; quasi-static, already in xgmii_clk domain
- if_macaddr  in  48  local MAC, bits [47:40] = first octet
- dest_v4addr  in  32  destination IPv4 address
- dest_macaddr  in  48  destination MAC
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  32  remote address
- req_data  in  32  write data
- req_be  in  4  byte enables
- xgmii_txd  out  64  XGMII data; lane 0 = bits [7:0], transmitted first
- xgmii_txc  out  8  XGMII control, one bit per lane
- frame_count  out  32  frames fully transmitted, wraps

## Operation
- States: IDLE, PRE, DATA (word counter 0..7), TERM, IFG.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, snapshot req_* and all four address inputs, then go to PRE.
  - Register changes after this point do not affect the frame in flight.
- PRE: txd = 64'hd5555555_555555fb, txc = 8'h01.
- DATA, eight words, txc = 8'h00. Frame byte b goes to word b/8, lane b%8. Bytes, MSB-first per field:
  - 0-5: dest MAC.
  - 6-11: src MAC.
  - 12-13: 08 00.
  - 14-33: IPv4 header = 45 00, total length 00 2e, ip_id, 40 00, TTL 40, protocol 11, checksum, src IP, dst IP.
  - 34-41: UDP = src port, dst port, length 00 1a, checksum 00 00.
  - 42-59: payload = OPCODE, req_addr, req_data, {4'h0, req_be}, then 7 bytes of 00.
  - 60-63: FCS.
- Checksums:
  - IPv4 checksum = one's complement of the 16-bit one's-complement sum over the header, with the checksum field taken as 0.
  - FCS = standard Ethernet CRC-32 over bytes 0-59: reflected poly 0xEDB88320, init 0xFFFFFFFF, final inversion, least-significant byte in lane 4 of word 7.
- TERM: txd = 64'h07070707_070707fd, txc = 8'hff.
- IFG: txd = 64'h07070707_07070707, txc = 8'hff, for one cycle, then IDLE. This gives ≥15 idle bytes between frames.
- ip_id:
  - 16-bit, reset 0.
  - Incremented when TERM is left; wraps 0xffff→0x0000.
  - The frame uses the value current at accept.
- frame_count increments in the same cycle as ip_id.
- IDLE output = idle word (txd all 0x07, txc 8'hff).

## Timing
- All outputs are registered.
- Reset values:
  - txd = 64'h07070707_07070707, txc = 8'hff
  - req_ready = 0 while rst is high; 1 in the first cycle after rst falls
  - frame_count = 0, ip_id = 0, state IDLE
- Latency: with an accept at edge k, PRE appears after edge k, DATA words 0-7 after edges k+1..k+8, TERM after k+9, IFG after k+10.
- req_ready is high again after edge k+11.
- Minimum frame period: 12 cycles, with back-to-back req_valid held high.
- req_ready is 0 from the accept edge until IDLE is re-entered. A req_valid held high during that time is not consumed and is accepted on re-entry.
- rst asserted mid-frame:
  - Next cycle outputs the idle word. The frame is abandoned without /T/, which is acceptable.
  - ip_id, frame_count and req_ready return to their reset values.
- Checksum and CRC may be computed across the DATA cycles, but each word must be presented in its specified cycle.

## Test plan
- Reset, defaults (if 10.0.21.199 / 00:37:76:00:00:01, dest 10.0.21.255 / broadcast): idle word out; req_ready = 1 one cycle after rst falls; frame_count = 0.
- Single request (addr 0x00001000, data 0xdeadbeef, be 0xf) with defaults:
  - PRE, then word 0 = 64'h3700ffff_ffffffff.
  - IP checksum bytes = fa f9.
  - Payload bytes 00 01 00 00 10 00 de ad be ef 0f.
  - FCS matches a reference CRC model.
  - TERM and IFG follow; frame_count = 1.
- req_valid held high for 3 requests: frames start 12 cycles apart; ip_id 0, 1, 2; each IP checksum recomputed correctly.
- Write dest_v4addr = 10.0.21.1 one cycle after accept: current frame still carries 10.0.21.255; next frame carries 10.0.21.1.
- Preload ip_id to 0xffff by sending 65535 frames (or force it): ip_id field = ff ff, then the next frame has 00 00.
- Assert rst during DATA word 3: next cycle idle word, txc = 8'hff; no TERM; frame_count unchanged at 0; normal frame after release.
